// File: rtl/fpna_pkg.sv
// fpna_pkg: shared definitions for the field-programmable LIF neuron array.
//   - default widths for the array and its neurons
//   - configuration slice / chain length helpers
//   - leak code enumeration
//   - signed saturation helper used by every neuron
package fpna_pkg;

  localparam int N_IN_DEF     = 10;
  localparam int N_OUT_DEF    = 10;
  localparam int W_BITS_DEF   = 3;
  localparam int POT_BITS_DEF = 6;

  // Wide working width for the saturation helper; must exceed any accumulator width.
  localparam int SAT_W = 32;

  // Leak code: how strongly the potential decays toward zero each cycle.
  typedef enum logic [1:0] {
    LEAK_NONE = 2'd0,
    LEAK_SLOW = 2'd1,
    LEAK_MED  = 2'd2,
    LEAK_FAST = 2'd3
  } leak_e;

  // Configuration bits held for one neuron: weights, threshold, 2-bit leak code.
  function automatic int slice_bits(input int n_in, input int w_bits, input int thr_bits);
    return n_in * w_bits + thr_bits + 2;
  endfunction

  // Total configuration chain length for the array.
  function automatic int cfg_bits(input int n_out, input int slice);
    return n_out * slice;
  endfunction

  // Clamp a signed value into the signed pot_bits range.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int pot_bits);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (32'sd1 <<< (pot_bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (pot_bits - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fpna_lif_array_neuron.sv
// fpna_lif_neuron: one leaky integrate-and-fire neuron.
// Ports:
//   clk, rst_n     clock and synchronous active-low full reset
//   reset_nn       synchronous active-low potential/spike clear
//   run            high when the array is configured and not shifting
//   cfg            this neuron's configuration slice (weights, thr, leak; LSB first)
//   in_spk         input spike vector
//   spk            registered output spike
module fpna_lif_neuron
  import fpna_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int W_BITS   = W_BITS_DEF,
  parameter int POT_BITS = POT_BITS_DEF,
  parameter int THR_BITS = POT_BITS - 1,
  localparam int SLICE   = slice_bits(N_IN, W_BITS, THR_BITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reset_nn,
  input  logic             run,
  input  logic [SLICE-1:0] cfg,
  input  logic [N_IN-1:0]  in_spk,
  output logic             spk
);

  // Wide enough that pot - decay + (N_IN weights) can never overflow before clamping.
  localparam int ACC_BITS = POT_BITS + $clog2(N_IN) + W_BITS;
  localparam int THR_OFS  = N_IN * W_BITS;
  localparam int LEAK_OFS = THR_OFS + THR_BITS;

  logic signed [POT_BITS-1:0] pot_q, pot_d;
  logic                       spk_q, spk_d;

  logic signed [W_BITS-1:0]   w_s;
  logic signed [ACC_BITS-1:0] sum_s;
  logic signed [ACC_BITS-1:0] pot_ext_s;
  logic signed [ACC_BITS-1:0] decay_s;
  logic signed [ACC_BITS-1:0] raw_s;
  logic signed [SAT_W-1:0]    sat_s;
  logic signed [SAT_W-1:0]    thr_ext_s;
  logic [THR_BITS-1:0]        thr_s;
  leak_e                      leak_s;
  logic                       fire_s;

  // Datapath: weighted input sum, leak, saturation and fire decision.
  always_comb begin
    w_s       = '0;
    sum_s     = '0;
    thr_s     = cfg[THR_OFS +: THR_BITS];
    leak_s    = leak_e'(cfg[LEAK_OFS +: 2]);
    pot_ext_s = {{(ACC_BITS-POT_BITS){pot_q[POT_BITS-1]}}, pot_q};

    for (int i = 0; i < N_IN; i++) begin
      w_s = cfg[i*W_BITS +: W_BITS];
      if (in_spk[i]) begin
        sum_s = sum_s + {{(ACC_BITS-W_BITS){w_s[W_BITS-1]}}, w_s};
      end else begin
        sum_s = sum_s;
      end
    end

    // Stronger leak codes shift by less, so a larger fraction of pot is removed.
    case (leak_s)
      LEAK_NONE: decay_s = '0;
      LEAK_SLOW: decay_s = pot_ext_s >>> 3'd3;
      LEAK_MED:  decay_s = pot_ext_s >>> 3'd2;
      LEAK_FAST: decay_s = pot_ext_s >>> 3'd1;
      default:   decay_s = '0;
    endcase

    raw_s     = pot_ext_s - decay_s + sum_s;
    sat_s     = saturate({{(SAT_W-ACC_BITS){raw_s[ACC_BITS-1]}}, raw_s}, POT_BITS);
    thr_ext_s = {{(SAT_W-THR_BITS){1'b0}}, thr_s};
    // A zero threshold disables firing; the neuron keeps integrating.
    fire_s    = (thr_s != '0) && (sat_s >= thr_ext_s);
  end

  // Next-state selection: clear has priority over compute; frozen otherwise.
  always_comb begin
    pot_d = pot_q;
    spk_d = 1'b0;
    if (!reset_nn) begin
      pot_d = '0;
      spk_d = 1'b0;
    end else if (run) begin
      if (fire_s) begin
        pot_d = '0;
        spk_d = 1'b1;
      end else begin
        pot_d = sat_s[POT_BITS-1:0];
        spk_d = 1'b0;
      end
    end else begin
      pot_d = pot_q;
      spk_d = 1'b0;
    end
  end

  // Potential and spike registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pot_q <= '0;
      spk_q <= 1'b0;
    end else begin
      pot_q <= pot_d;
      spk_q <= spk_d;
    end
  end

  assign spk = spk_q;

endmodule

// File: rtl/fpna_lif_array.sv
// fpna_lif_array: N_OUT LIF neurons fully connected to N_IN spike inputs,
// configured through one serial shift chain.
// Ports:
//   clk, rst_n   clock and synchronous active-low full reset
//   config_en    high: shift configuration chain, neurons frozen
//   bs_in        serial configuration input (enters at the chain MSB)
//   bs_out       registered chain tail for daisy-chaining / readback
//   reset_nn     synchronous active-low neuron state clear (configuration kept)
//   in_spk       input spikes, sampled every clock
//   out_spk      registered output spikes, one per neuron
//   cfg_valid    high once exactly a full chain has been loaded
module fpna_lif_array
  import fpna_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int N_OUT    = N_OUT_DEF,
  parameter int W_BITS   = W_BITS_DEF,
  parameter int POT_BITS = POT_BITS_DEF,
  parameter int THR_BITS = POT_BITS - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             config_en,
  input  logic             bs_in,
  output logic             bs_out,
  input  logic             reset_nn,
  input  logic [N_IN-1:0]  in_spk,
  output logic [N_OUT-1:0] out_spk,
  output logic             cfg_valid
);

  localparam int SLICE    = slice_bits(N_IN, W_BITS, THR_BITS);
  localparam int CFG_LEN  = cfg_bits(N_OUT, SLICE);
  localparam int CNT_BITS = $clog2(CFG_LEN + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(CFG_LEN);

  logic [CFG_LEN-1:0]  chain_q, chain_d;
  logic                bs_out_q, bs_out_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                cfg_en_prev_q, cfg_en_prev_d;
  logic                run_s;

  // Chain shift, bit counting and configuration-complete decision.
  always_comb begin
    chain_d       = chain_q;
    bs_out_d      = bs_out_q;
    cnt_d         = cnt_q;
    cfg_valid_d   = cfg_valid_q;
    cfg_en_prev_d = config_en;
    if (config_en) begin
      chain_d  = {bs_in, chain_q[CFG_LEN-1:1]};
      bs_out_d = chain_q[0];
      if (!cfg_en_prev_q) begin
        // First shift cycle of a new load: this cycle's bit is bit number one.
        cnt_d       = CNT_BITS'(1);
        cfg_valid_d = 1'b0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end else begin
        // Saturate: extra bits push older ones out, the newest CFG_LEN win.
        cnt_d = cnt_q;
      end
    end else begin
      if (cfg_en_prev_q) begin
        cfg_valid_d = (cnt_q == CNT_MAX);
      end else begin
        cfg_valid_d = cfg_valid_q;
      end
    end
  end

  // Configuration state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q       <= '0;
      bs_out_q      <= 1'b0;
      cfg_valid_q   <= 1'b0;
      cnt_q         <= '0;
      cfg_en_prev_q <= 1'b0;
    end else begin
      chain_q       <= chain_d;
      bs_out_q      <= bs_out_d;
      cfg_valid_q   <= cfg_valid_d;
      cnt_q         <= cnt_d;
      cfg_en_prev_q <= cfg_en_prev_d;
    end
  end

  assign run_s     = cfg_valid_q & ~config_en;
  assign bs_out    = bs_out_q;
  assign cfg_valid = cfg_valid_q;

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    fpna_lif_neuron #(
      .N_IN     (N_IN),
      .W_BITS   (W_BITS),
      .POT_BITS (POT_BITS),
      .THR_BITS (THR_BITS)
    ) u_neuron (
      .clk      (clk),
      .rst_n    (rst_n),
      .reset_nn (reset_nn),
      .run      (run_s),
      .cfg      (chain_q[j*SLICE +: SLICE]),
      .in_spk   (in_spk),
      .spk      (out_spk[j])
    );
  end

endmodule

// File: tb/tb_fpna_lif_array.sv
// Self-checking bench for fpna_lif_array: an integer-level behavioural model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_fpna_lif_array;
  import fpna_pkg::*;

  localparam int N_IN     = 10;
  localparam int N_OUT    = 10;
  localparam int W_BITS   = 3;
  localparam int POT_BITS = 6;
  localparam int THR_BITS = POT_BITS - 1;
  localparam int SLICE    = slice_bits(N_IN, W_BITS, THR_BITS);
  localparam int CFG_LEN  = cfg_bits(N_OUT, SLICE);
  localparam int POT_MAX  = (1 << (POT_BITS - 1)) - 1;
  localparam int POT_MIN  = -(1 << (POT_BITS - 1));

  logic             clk = 1'b0;
  logic             rst_n, config_en, bs_in, reset_nn;
  logic [N_IN-1:0]  in_spk;
  logic             bs_out, cfg_valid;
  logic [N_OUT-1:0] out_spk;

  int n_total = 0;
  int n_pass  = 0;

  logic [CFG_LEN-1:0] cfg_vec;
  logic [CFG_LEN-1:0] p1, p2;
  logic [5:0]         fire_pat;

  // model state
  bit m_chain[CFG_LEN];
  int m_pot[N_OUT];
  bit m_spk[N_OUT];
  bit m_bs, m_cv, m_prev_en;
  int m_cnt;

  fpna_lif_array #(
    .N_IN(N_IN), .N_OUT(N_OUT), .W_BITS(W_BITS), .POT_BITS(POT_BITS), .THR_BITS(THR_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .config_en(config_en), .bs_in(bs_in), .bs_out(bs_out),
    .reset_nn(reset_nn), .in_spk(in_spk), .out_spk(out_spk), .cfg_valid(cfg_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // unsigned field of the model chain
  function automatic int field(input int base, input int width);
    int v = 0;
    for (int b = 0; b < width; b++) v = v | (int'(m_chain[base + b]) << b);
    return v;
  endfunction

  function automatic int weight(input int j, input int i);
    int v = field(j*SLICE + i*W_BITS, W_BITS);
    if (v >= (1 << (W_BITS - 1))) v = v - (1 << W_BITS);
    return v;
  endfunction

  // Behavioural model: advances once per rising clock edge from the sampled inputs.
  always @(posedge clk) begin : model_step
    bit cv_old;
    int sum, decay, raw, thr, lk;
    if (!rst_n) begin
      foreach (m_chain[k]) m_chain[k] = 1'b0;
      foreach (m_pot[j]) begin m_pot[j] = 0; m_spk[j] = 1'b0; end
      m_bs = 1'b0; m_cv = 1'b0; m_cnt = 0; m_prev_en = 1'b0;
    end else begin
      cv_old = m_cv;
      if (config_en) begin
        m_bs = m_chain[0];
        for (int k = 0; k < CFG_LEN - 1; k++) m_chain[k] = m_chain[k+1];
        m_chain[CFG_LEN-1] = bs_in;
        if (!m_prev_en) begin m_cnt = 1; m_cv = 1'b0; end
        else if (m_cnt < CFG_LEN) m_cnt++;
      end else if (m_prev_en) begin
        m_cv = (m_cnt == CFG_LEN);
      end
      for (int j = 0; j < N_OUT; j++) begin
        if (!reset_nn) begin
          m_pot[j] = 0; m_spk[j] = 1'b0;
        end else if (config_en || !cv_old) begin
          m_spk[j] = 1'b0;
        end else begin
          sum = 0;
          for (int i = 0; i < N_IN; i++) if (in_spk[i]) sum += weight(j, i);
          thr   = field(j*SLICE + N_IN*W_BITS, THR_BITS);
          lk    = field(j*SLICE + N_IN*W_BITS + THR_BITS, 2);
          decay = (lk == 0) ? 0 : (m_pot[j] >>> (4 - lk));
          raw   = m_pot[j] - decay + sum;
          if (raw > POT_MAX) raw = POT_MAX;
          if (raw < POT_MIN) raw = POT_MIN;
          if (thr != 0 && raw >= thr) begin m_spk[j] = 1'b1; m_pot[j] = 0; end
          else begin m_spk[j] = 1'b0; m_pot[j] = raw; end
        end
      end
      m_prev_en = config_en;
    end
  end

  // Compare process: checks DUT outputs against the model shortly after every edge.
  always @(posedge clk) begin : compare
    logic [N_OUT-1:0] exp_spk;
    #1;
    for (int j = 0; j < N_OUT; j++) exp_spk[j] = m_spk[j];
    chk("model_out_spk", 64'(out_spk), 64'(exp_spk));
    chk("model_cfg_valid", 64'(cfg_valid), 64'(m_cv));
    chk("model_bs_out", 64'(bs_out), 64'(m_bs));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [CFG_LEN-1:0] v, input int nbits);
    config_en = 1'b1;
    for (int k = 0; k < nbits; k++) begin bs_in = v[k]; tick(); end
    config_en = 1'b0;
    bs_in = 1'b0;
    tick();
  endtask

  task automatic clear_nn();
    reset_nn = 1'b0; tick(); reset_nn = 1'b1;
  endtask

  task automatic set_w(input int j, input int i, input int w);
    for (int b = 0; b < W_BITS; b++) cfg_vec[j*SLICE + i*W_BITS + b] = w[b];
  endtask

  task automatic set_thr_leak(input int j, input int thr, input int lk);
    for (int b = 0; b < THR_BITS; b++) cfg_vec[j*SLICE + N_IN*W_BITS + b] = thr[b];
    for (int b = 0; b < 2; b++) cfg_vec[j*SLICE + N_IN*W_BITS + THR_BITS + b] = lk[b];
  endtask

  initial begin
    rst_n = 1'b0; config_en = 1'b0; bs_in = 1'b0; reset_nn = 1'b1; in_spk = '0;
    tick(); tick();
    chk("reset_out_spk", 64'(out_spk), 64'd0);
    chk("reset_cfg_valid", 64'(cfg_valid), 64'd0);
    chk("reset_bs_out", 64'(bs_out), 64'd0);
    rst_n = 1'b1;
    tick();

    // Readback: second pattern pushes the first out of bs_out bit-exact.
    for (int k = 0; k < CFG_LEN; k++) begin p1[k] = 1'($urandom()); p2[k] = 1'($urandom()); end
    config_en = 1'b1;
    for (int k = 0; k < CFG_LEN; k++) begin bs_in = p1[k]; tick(); end
    for (int k = 0; k < CFG_LEN; k++) begin
      bs_in = p2[k]; tick();
      chk("readback_bit", 64'(bs_out), 64'(p1[k]));
    end
    config_en = 1'b0; tick();
    chk("readback_cfg_valid", 64'(cfg_valid), 64'd1);
    for (int c = 0; c < 20; c++) begin in_spk = N_IN'($urandom()); tick(); end
    in_spk = '0;

    // Firing: w=3, thr=7, no leak -> potential 3, 6, fire; period 3.
    cfg_vec = '0; set_w(0, 0, 3); set_thr_leak(0, 7, 0);
    load(cfg_vec, CFG_LEN);
    clear_nn();
    chk("fire_cfg_valid", 64'(cfg_valid), 64'd1);
    fire_pat = 6'b100100;
    in_spk = 10'b0000000001;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("fire_pattern", 64'(out_spk), 64'(fire_pat[c]));
      if (c == 0) chk("model_pot_3", 64'(m_pot[0]), 64'(3));
      if (c == 1) chk("model_pot_6", 64'(m_pot[0]), 64'(6));
    end

    // reset_nn mid-period: cleared next cycle, period restarts from zero.
    tick();
    reset_nn = 1'b0; tick();
    chk("reset_nn_out_spk", 64'(out_spk), 64'd0);
    chk("reset_nn_model_pot", 64'(m_pot[0]), 64'(0));
    reset_nn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("resume_pattern", 64'(out_spk), 64'(fire_pat[c]));
    end

    // Leak: w=1, thr=31, fastest leak -> potential settles at 2, never fires.
    cfg_vec = '0; set_w(0, 0, 1); set_thr_leak(0, 31, 3);
    in_spk = '0;
    load(cfg_vec, CFG_LEN);
    clear_nn();
    in_spk = 10'b0000000001;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("leak_no_fire", 64'(out_spk), 64'd0);
      if (c == 0) chk("leak_model_pot_1", 64'(m_pot[0]), 64'(1));
    end
    chk("leak_model_pot_steady", 64'(m_pot[0]), 64'(2));

    // Saturation: w0=+3, others -4, thr=5; all inputs clamp at -32, then climb.
    cfg_vec = '0; set_w(0, 0, 3);
    for (int i = 1; i < N_IN; i++) set_w(0, i, -4);
    set_thr_leak(0, 5, 0);
    in_spk = '0;
    load(cfg_vec, CFG_LEN);
    clear_nn();
    in_spk = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("sat_model_pot", 64'(m_pot[0]), 64'(-32));
      chk("sat_no_fire", 64'(out_spk), 64'd0);
    end
    in_spk = 10'b0000000001;
    for (int c = 1; c <= 13; c++) begin
      tick();
      chk("sat_climb", 64'(out_spk), (c == 13) ? 64'd1 : 64'd0);
    end

    // Partial configuration: one bit short leaves the array disabled.
    in_spk = '0;
    load(cfg_vec, CFG_LEN - 1);
    chk("partial_cfg_valid", 64'(cfg_valid), 64'd0);
    for (int c = 0; c < 10; c++) begin
      in_spk = N_IN'($urandom()) | 10'b0000000001;
      tick();
      chk("partial_out_spk", 64'(out_spk), 64'd0);
    end

    // rst_n during a load aborts it.
    in_spk = '0;
    load(cfg_vec, CFG_LEN);
    chk("reload_cfg_valid", 64'(cfg_valid), 64'd1);
    config_en = 1'b1;
    for (int k = 0; k < 50; k++) begin bs_in = 1'b1; tick(); end
    rst_n = 1'b0; tick();
    chk("abort_bs_out", 64'(bs_out), 64'd0);
    rst_n = 1'b1; config_en = 1'b0; bs_in = 1'b0; tick();
    chk("abort_cfg_valid", 64'(cfg_valid), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
